// File: rtl/mem_pkg.sv
// mem_pkg: shared types and defaults for the simple dual-port RAM.
//   rdw_mode_e  - read/write collision policy
//   clr_state_e - zero-fill sequencer states
//   word_t      - default 16-bit data word
//   addr_w()    - address width for a given depth (never below 1 bit)
package mem_pkg;

   typedef enum logic {
      RDW_READ_FIRST,
      RDW_WRITE_FIRST
   } rdw_mode_e;

   typedef enum logic {
      CLEAR,
      READY
   } clr_state_e;

   localparam int unsigned DEF_WIDTH  = 16;
   localparam int unsigned DEF_DEPTH  = 256;
   localparam int unsigned DEF_LANE_W = 8;

   typedef logic [DEF_WIDTH-1:0] word_t;

   function automatic int unsigned addr_w(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/mem_clear_seq.sv
// mem_clear_seq: zero-fill sequencer that walks every address once after reset.
//   clk      in   rising-edge clock
//   rst_n    in   synchronous active-low reset; restarts the walk at address 0
//   busy     out  high while the walk is in progress
//   clr_we   out  write strobe for the zero word
//   clr_addr out  address being zeroed this cycle
module mem_clear_seq
   import mem_pkg::*;
#(
   parameter int unsigned DEPTH          = DEF_DEPTH,
   parameter bit          CLEAR_ON_RESET = 1'b1,
   localparam int unsigned AW            = addr_w(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   output logic          busy,
   output logic          clr_we,
   output logic [AW-1:0] clr_addr
);

   localparam clr_state_e RST_STATE = CLEAR_ON_RESET ? CLEAR : READY;
   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

   clr_state_e    state_q, state_d;
   logic [AW-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= RST_STATE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      busy    = 1'b0;
      clr_we  = 1'b0;
      case (state_q)
         CLEAR: begin
            busy   = 1'b1;
            clr_we = 1'b1;
            cnt_d  = cnt_q + AW'(1);
            // busy drops on the same edge that zeroes the last word
            if (cnt_q == LAST_ADDR) begin
               state_d = READY;
               cnt_d   = '0;
            end
         end
         READY: begin
            state_d = READY;
         end
         default: begin
            state_d = READY;
         end
      endcase
   end

   assign clr_addr = cnt_q;

endmodule

// File: rtl/mem_sdp_ram.sv
// mem_sdp_ram: parametrised simple dual-port synchronous RAM (one write port,
// one read port, one clock) with byte-lane writes, selectable collision policy,
// 1- or 2-cycle read latency and an optional zero-fill after reset.
//   clk      in   rising-edge clock
//   rst_n    in   synchronous active-low reset (control only; array untouched)
//   wr_en    in   write request
//   wr_addr  in   write address
//   wr_data  in   write data
//   wr_be    in   lane enables, bit i covers wr_data[i*LANE_W +: LANE_W]
//   rd_en    in   read request
//   rd_addr  in   read address
//   rd_data  out  read result, holds between results
//   rd_valid out  one-cycle strobe marking a new rd_data
//   busy     out  zero-fill in progress; both ports ignored
module mem_sdp_ram
   import mem_pkg::*;
#(
   parameter int unsigned WIDTH          = DEF_WIDTH,
   parameter int unsigned DEPTH          = DEF_DEPTH,
   parameter int unsigned LANE_W         = DEF_LANE_W,
   parameter int unsigned RD_LATENCY     = 1,
   parameter rdw_mode_e   RDW_MODE       = RDW_READ_FIRST,
   parameter bit          CLEAR_ON_RESET = 1'b1,
   localparam int unsigned AW            = addr_w(DEPTH),
   localparam int unsigned NLANE         = WIDTH / LANE_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [NLANE-1:0] wr_be,
   input  logic             rd_en,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data,
   output logic             rd_valid,
   output logic             busy
);

   if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
      $error("mem_sdp_ram: RD_LATENCY must be 1 or 2");
   end
   if (WIDTH % LANE_W != 0) begin : g_bad_lane
      $error("mem_sdp_ram: WIDTH must be a multiple of LANE_W");
   end

   logic [WIDTH-1:0] mem_q [DEPTH];

   logic          clr_we;
   logic [AW-1:0] clr_addr;

   mem_clear_seq #(
      .DEPTH         (DEPTH),
      .CLEAR_ON_RESET(CLEAR_ON_RESET)
   ) u_clear_seq (
      .clk     (clk),
      .rst_n   (rst_n),
      .busy    (busy),
      .clr_we  (clr_we),
      .clr_addr(clr_addr)
   );

   logic             wr_acc, rd_acc;
   logic             wr_in_rng, rd_in_rng;
   logic [WIDTH-1:0] rd_old, rd_word;

   assign wr_acc    = wr_en & ~busy;
   assign rd_acc    = rd_en & ~busy;
   assign wr_in_rng = 32'(wr_addr) < DEPTH;
   assign rd_in_rng = 32'(rd_addr) < DEPTH;
   assign rd_old    = rd_in_rng ? mem_q[rd_addr] : '0;

   // Write-first collisions see the merged word: enabled lanes from the
   // write port, the rest from the array.
   always_comb begin
      rd_word = rd_old;
      if (RDW_MODE == RDW_WRITE_FIRST && wr_acc && rd_in_rng && wr_addr == rd_addr) begin
         for (int i = 0; i < NLANE; i++) begin
            if (wr_be[i]) rd_word[i*LANE_W +: LANE_W] = wr_data[i*LANE_W +: LANE_W];
         end
      end
   end

   // Array: no writes on reset edges, so reset alone never alters contents.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (clr_we) begin
            mem_q[clr_addr] <= '0;
         end else if (wr_acc && wr_in_rng) begin
            for (int i = 0; i < NLANE; i++) begin
               if (wr_be[i]) mem_q[wr_addr][i*LANE_W +: LANE_W] <= wr_data[i*LANE_W +: LANE_W];
            end
         end
      end
   end

   // ---- stage p1: array read register ----
   logic [WIDTH-1:0] rd_data_p1_q;
   logic             vld_p1_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_data_p1_q <= '0;
         vld_p1_q     <= 1'b0;
      end else begin
         vld_p1_q <= rd_acc;
         if (rd_acc) rd_data_p1_q <= rd_word;
      end
   end

   // ---- stage p2: optional output register ----
   if (RD_LATENCY == 2) begin : g_lat2
      logic [WIDTH-1:0] rd_data_p2_q;
      logic             vld_p2_q;

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            rd_data_p2_q <= '0;
            vld_p2_q     <= 1'b0;
         end else begin
            vld_p2_q <= vld_p1_q;
            if (vld_p1_q) rd_data_p2_q <= rd_data_p1_q;
         end
      end

      assign rd_data  = rd_data_p2_q;
      assign rd_valid = vld_p2_q;
   end else begin : g_lat1
      assign rd_data  = rd_data_p1_q;
      assign rd_valid = vld_p1_q;
   end

endmodule

// File: tb/tb_mem_sdp_ram.sv
module tb_mem_sdp_ram;
   import mem_pkg::*;

   localparam int NI = 3;

   typedef struct {
      logic [15:0] d;
      int          cyc;
      bit          dc;
   } rsp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        wr_en;
   logic [7:0]  wr_addr;
   logic [15:0] wr_data;
   logic [1:0]  wr_be;
   logic        rd_en;
   logic [7:0]  rd_addr;

   logic [15:0] rd_data_w  [NI];
   logic        rd_valid_w [NI];
   logic        busy_w     [NI];

   // inst0: read-first, latency 1, 256 deep, zero-fill
   mem_sdp_ram #(.WIDTH(16), .DEPTH(256), .LANE_W(8), .RD_LATENCY(1),
                 .RDW_MODE(RDW_READ_FIRST), .CLEAR_ON_RESET(1'b1)) u_rf_l1 (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_w[0]),
      .rd_valid(rd_valid_w[0]), .busy(busy_w[0]));

   // inst1: write-first, latency 2, 256 deep, zero-fill
   mem_sdp_ram #(.WIDTH(16), .DEPTH(256), .LANE_W(8), .RD_LATENCY(2),
                 .RDW_MODE(RDW_WRITE_FIRST), .CLEAR_ON_RESET(1'b1)) u_wf_l2 (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_w[1]),
      .rd_valid(rd_valid_w[1]), .busy(busy_w[1]));

   // inst2: read-first, latency 1, 200 deep, no zero-fill
   mem_sdp_ram #(.WIDTH(16), .DEPTH(200), .LANE_W(8), .RD_LATENCY(1),
                 .RDW_MODE(RDW_READ_FIRST), .CLEAR_ON_RESET(1'b0)) u_d200 (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_w[2]),
      .rd_valid(rd_valid_w[2]), .busy(busy_w[2]));

   int dep_c [NI] = '{256, 256, 200};
   int lat_c [NI] = '{1, 2, 1};
   bit wf_c  [NI] = '{1'b0, 1'b1, 1'b0};
   bit clr_c [NI] = '{1'b1, 1'b1, 1'b0};

   logic [15:0] mdl_mem   [NI][256];
   bit          mdl_known [NI][256];
   bit          mdl_busy  [NI];
   int          mdl_cnt   [NI];

   rsp_t        exp_q [NI][$];
   rsp_t        obs_q [NI][$];
   logic [15:0] last_obs [NI];

   int cyc    = 0;
   int errors = 0;
   int checks = 0;

   // Drive one cycle of stimulus, update the reference model at the edge and
   // capture any DUT read results half a cycle later.
   task automatic step(input bit we, input logic [7:0] wa, input logic [15:0] wd,
                       input logic [1:0] be, input bit re, input logic [7:0] ra);
      rsp_t r;
      wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
      rd_en = re; rd_addr = ra;
      @(posedge clk);
      cyc++;
      for (int i = 0; i < NI; i++) begin
         if (!rst_n) begin
            while (exp_q[i].size() > 0 && exp_q[i][exp_q[i].size()-1].cyc >= cyc)
               void'(exp_q[i].pop_back());
            mdl_busy[i] = clr_c[i];
            mdl_cnt[i]  = 0;
         end else if (mdl_busy[i]) begin
            mdl_mem[i][mdl_cnt[i]]   = 16'h0000;
            mdl_known[i][mdl_cnt[i]] = 1'b1;
            if (mdl_cnt[i] == dep_c[i] - 1) mdl_busy[i] = 1'b0;
            mdl_cnt[i]++;
         end else begin
            if (re) begin
               r.cyc = cyc + lat_c[i] - 1;
               if (int'(ra) >= dep_c[i]) begin
                  r.d = 16'h0000; r.dc = 1'b0;
               end else begin
                  r.d  = mdl_mem[i][ra];
                  r.dc = !mdl_known[i][ra];
                  if (wf_c[i] && we && wa == ra) begin
                     for (int l = 0; l < 2; l++) if (be[l]) r.d[l*8 +: 8] = wd[l*8 +: 8];
                     if (be == 2'b11) r.dc = 1'b0;
                  end
               end
               exp_q[i].push_back(r);
            end
            if (we && int'(wa) < dep_c[i]) begin
               for (int l = 0; l < 2; l++) if (be[l]) mdl_mem[i][wa][l*8 +: 8] = wd[l*8 +: 8];
               if (be == 2'b11) mdl_known[i][wa] = 1'b1;
            end
         end
      end
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
         if (rd_valid_w[i] === 1'b1) begin
            r.d = rd_data_w[i]; r.cyc = cyc; r.dc = 1'b0;
            obs_q[i].push_back(r);
            last_obs[i] = rd_data_w[i];
         end
      end
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b0, 8'd0, 16'h0000, 2'b00, 1'b0, 8'd0);
   endtask

   task automatic test_reset;
      int n;
      rst_n = 1'b0;
      idle(2);
      for (int i = 0; i < NI; i++) begin
         checks++;
         if (rd_valid_w[i] !== 1'b0) begin
            errors++; $display("FAIL reset_valid inst%0d: got %b, required 0", i, rd_valid_w[i]);
         end
         checks++;
         if (rd_data_w[i] !== 16'h0000) begin
            errors++; $display("FAIL reset_data inst%0d: got %h, required 0000", i, rd_data_w[i]);
         end
         checks++;
         if (busy_w[i] !== clr_c[i]) begin
            errors++; $display("FAIL reset_busy inst%0d: got %b, required %b", i, busy_w[i], clr_c[i]);
         end
      end
      rst_n = 1'b1;
      n = 0;
      for (int k = 0; k < 600 && busy_w[0] === 1'b1; k++) begin
         n++;
         idle(1);
      end
      checks++;
      if (n != 256) begin
         errors++; $display("FAIL reset_clear_len: busy for %0d cycles, required 256", n);
      end
      checks++;
      if (busy_w[1] !== 1'b0) begin
         errors++; $display("FAIL reset_clear_inst1: busy=%b, required 0", busy_w[1]);
      end
   endtask

   task automatic test_clear;
      int n;
      rsp_t e, o;
      step(1'b1, 8'd5, 16'hBEEF, 2'b11, 1'b0, 8'd0);
      step(1'b0, 8'd0, 16'h0000, 2'b00, 1'b1, 8'd5);
      rst_n = 1'b0;
      idle(1);
      rst_n = 1'b1;
      n = 0;
      for (int k = 0; k < 600 && busy_w[0] === 1'b1; k++) begin
         n++;
         // last busy cycle: this write must be dropped by the cleared instances
         if (mdl_cnt[0] == 255) step(1'b1, 8'd3, 16'h7777, 2'b11, 1'b1, 8'd5);
         else idle(1);
      end
      checks++;
      if (n != 256) begin
         errors++; $display("FAIL clear_len: busy for %0d cycles, required 256", n);
      end
      step(1'b0, 8'd0, 16'h0000, 2'b00, 1'b1, 8'd5);
      checks++;
      if (rd_valid_w[0] !== 1'b1 || rd_data_w[0] !== 16'h0000) begin
         errors++; $display("FAIL clear_addr5: got %h valid %b, required 0000 valid 1", rd_data_w[0], rd_valid_w[0]);
      end
      step(1'b0, 8'd0, 16'h0000, 2'b00, 1'b1, 8'd3);
      checks++;
      if (rd_valid_w[0] !== 1'b1 || rd_data_w[0] !== 16'h0000) begin
         errors++; $display("FAIL clear_busy_write: got %h valid %b, required 0000 valid 1", rd_data_w[0], rd_valid_w[0]);
      end
      checks++;
      if (rd_data_w[2] !== 16'h7777) begin
         errors++; $display("FAIL clear_noclr_write: got %h, required 7777", rd_data_w[2]);
      end
      idle(3);
      for (int i = 0; i < NI; i++) begin
         checks++;
         if (obs_q[i].size() != exp_q[i].size()) begin
            errors++; $display("FAIL clear_count inst%0d: got %0d results, required %0d", i, obs_q[i].size(), exp_q[i].size());
         end
         while (exp_q[i].size() > 0 && obs_q[i].size() > 0) begin
            e = exp_q[i].pop_front(); o = obs_q[i].pop_front(); checks++;
            if (o.cyc != e.cyc || (!e.dc && o.d !== e.d)) begin
               errors++; $display("FAIL clear_data inst%0d: got %h @%0d, required %h @%0d", i, o.d, o.cyc, e.d, e.cyc);
            end
         end
         exp_q[i].delete(); obs_q[i].delete();
      end
   endtask

   task automatic test_byte_lanes;
      rsp_t e, o;
      step(1'b1, 8'd3, 16'h1234, 2'b11, 1'b0, 8'd0);
      step(1'b1, 8'd3, 16'hAB00, 2'b10, 1'b0, 8'd0);
      step(1'b1, 8'd3, 16'hFFFF, 2'b00, 1'b1, 8'd3);
      step(1'b0, 8'd0, 16'h0000, 2'b00, 1'b1, 8'd3);
      idle(2);
      for (int i = 0; i < NI; i++) begin
         checks++;
         if (last_obs[i] !== 16'hAB34) begin
            errors++; $display("FAIL lanes_merge inst%0d: got %h, required ab34", i, last_obs[i]);
         end
      end
      for (int i = 0; i < NI; i++) begin
         checks++;
         if (obs_q[i].size() != exp_q[i].size()) begin
            errors++; $display("FAIL lanes_count inst%0d: got %0d results, required %0d", i, obs_q[i].size(), exp_q[i].size());
         end
         while (exp_q[i].size() > 0 && obs_q[i].size() > 0) begin
            e = exp_q[i].pop_front(); o = obs_q[i].pop_front(); checks++;
            if (o.cyc != e.cyc || (!e.dc && o.d !== e.d)) begin
               errors++; $display("FAIL lanes_data inst%0d: got %h @%0d, required %h @%0d", i, o.d, o.cyc, e.d, e.cyc);
            end
         end
         exp_q[i].delete(); obs_q[i].delete();
      end
   endtask

   task automatic test_collision;
      rsp_t e, o;
      step(1'b1, 8'd7, 16'h1111, 2'b11, 1'b0, 8'd0);
      step(1'b1, 8'd7, 16'h2222, 2'b11, 1'b1, 8'd7);
      idle(2);
      checks++;
      if (last_obs[0] !== 16'h1111) begin
         errors++; $display("FAIL coll_read_first: got %h, required 1111", last_obs[0]);
      end
      checks++;
      if (last_obs[1] !== 16'h2222) begin
         errors++; $display("FAIL coll_write_first: got %h, required 2222", last_obs[1]);
      end
      checks++;
      if (last_obs[2] !== 16'h1111) begin
         errors++; $display("FAIL coll_read_first_d200: got %h, required 1111", last_obs[2]);
      end
      step(1'b0, 8'd0, 16'h0000, 2'b00, 1'b1, 8'd7);
      idle(2);
      for (int i = 0; i < NI; i++) begin
         checks++;
         if (last_obs[i] !== 16'h2222) begin
            errors++; $display("FAIL coll_after inst%0d: got %h, required 2222", i, last_obs[i]);
         end
      end
      for (int i = 0; i < NI; i++) begin
         checks++;
         if (obs_q[i].size() != exp_q[i].size()) begin
            errors++; $display("FAIL coll_count inst%0d: got %0d results, required %0d", i, obs_q[i].size(), exp_q[i].size());
         end
         while (exp_q[i].size() > 0 && obs_q[i].size() > 0) begin
            e = exp_q[i].pop_front(); o = obs_q[i].pop_front(); checks++;
            if (o.cyc != e.cyc || (!e.dc && o.d !== e.d)) begin
               errors++; $display("FAIL coll_data inst%0d: got %h @%0d, required %h @%0d", i, o.d, o.cyc, e.d, e.cyc);
            end
         end
         exp_q[i].delete(); obs_q[i].delete();
      end
   endtask

   task automatic test_back_to_back;
      rsp_t e, o;
      int first;
      for (int a = 0; a < 3; a++) step(1'b1, 8'(a), 16'hA000 + 16'(a), 2'b11, 1'b0, 8'd0);
      first = cyc + 1;
      for (int a = 0; a < 3; a++) step(1'b0, 8'd0, 16'h0000, 2'b00, 1'b1, 8'(a));
      idle(3);
      checks++;
      if (obs_q[0].size() != 3 || obs_q[1].size() != 3) begin
         errors++; $display("FAIL b2b_count: got %0d/%0d results, required 3/3", obs_q[0].size(), obs_q[1].size());
      end else begin
         for (int j = 0; j < 3; j++) begin
            checks++;
            if (obs_q[0][j].cyc != first + j || obs_q[0][j].d !== 16'hA000 + 16'(j)) begin
               errors++; $display("FAIL b2b_lat1 #%0d: got %h @%0d, required %h @%0d", j, obs_q[0][j].d, obs_q[0][j].cyc, 16'hA000 + 16'(j), first + j);
            end
            checks++;
            if (obs_q[1][j].cyc != first + j + 1 || obs_q[1][j].d !== 16'hA000 + 16'(j)) begin
               errors++; $display("FAIL b2b_lat2 #%0d: got %h @%0d, required %h @%0d", j, obs_q[1][j].d, obs_q[1][j].cyc, 16'hA000 + 16'(j), first + j + 1);
            end
         end
      end
      for (int i = 0; i < NI; i++) begin
         checks++;
         if (obs_q[i].size() != exp_q[i].size()) begin
            errors++; $display("FAIL b2b_sb_count inst%0d: got %0d results, required %0d", i, obs_q[i].size(), exp_q[i].size());
         end
         while (exp_q[i].size() > 0 && obs_q[i].size() > 0) begin
            e = exp_q[i].pop_front(); o = obs_q[i].pop_front(); checks++;
            if (o.cyc != e.cyc || (!e.dc && o.d !== e.d)) begin
               errors++; $display("FAIL b2b_data inst%0d: got %h @%0d, required %h @%0d", i, o.d, o.cyc, e.d, e.cyc);
            end
         end
         exp_q[i].delete(); obs_q[i].delete();
      end
   endtask

   task automatic test_busy_gating;
      rsp_t e, o;
      int n;
      // read into the 2-cycle pipeline, then reset before it emerges
      step(1'b0, 8'd0, 16'h0000, 2'b00, 1'b1, 8'd5);
      rst_n = 1'b0;
      idle(1);
      rst_n = 1'b1;
      checks++;
      if (rd_valid_w[1] !== 1'b0 || rd_data_w[1] !== 16'h0000) begin
         errors++; $display("FAIL midpipe_reset: got %h valid %b, required 0000 valid 0", rd_data_w[1], rd_valid_w[1]);
      end
      step(1'b1, 8'd9, 16'h5A5A, 2'b11, 1'b1, 8'd9);
      checks++;
      if (rd_valid_w[0] !== 1'b0) begin
         errors++; $display("FAIL busy_read: valid=%b, required 0", rd_valid_w[0]);
      end
      for (int k = 0; k < 300 && mdl_cnt[0] != 100; k++) idle(1);
      rst_n = 1'b0;
      idle(1);
      rst_n = 1'b1;
      n = 0;
      for (int k = 0; k < 600 && busy_w[0] === 1'b1; k++) begin
         n++;
         idle(1);
      end
      checks++;
      if (n != 256) begin
         errors++; $display("FAIL busy_restart_len: busy for %0d cycles, required 256", n);
      end
      step(1'b0, 8'd0, 16'h0000, 2'b00, 1'b1, 8'd9);
      idle(2);
      checks++;
      if (last_obs[0] !== 16'h0000 || last_obs[1] !== 16'h0000) begin
         errors++; $display("FAIL busy_write_lost: got %h/%h, required 0000/0000", last_obs[0], last_obs[1]);
      end
      checks++;
      if (last_obs[2] !== 16'h5A5A) begin
         errors++; $display("FAIL busy_noclr_write: got %h, required 5a5a", last_obs[2]);
      end
      for (int i = 0; i < NI; i++) begin
         checks++;
         if (obs_q[i].size() != exp_q[i].size()) begin
            errors++; $display("FAIL busy_count inst%0d: got %0d results, required %0d", i, obs_q[i].size(), exp_q[i].size());
         end
         while (exp_q[i].size() > 0 && obs_q[i].size() > 0) begin
            e = exp_q[i].pop_front(); o = obs_q[i].pop_front(); checks++;
            if (o.cyc != e.cyc || (!e.dc && o.d !== e.d)) begin
               errors++; $display("FAIL busy_data inst%0d: got %h @%0d, required %h @%0d", i, o.d, o.cyc, e.d, e.cyc);
            end
         end
         exp_q[i].delete(); obs_q[i].delete();
      end
   endtask

   task automatic test_out_of_range;
      rsp_t e, o;
      step(1'b1, 8'd50, 16'h0050, 2'b11, 1'b0, 8'd0);
      step(1'b1, 8'd250, 16'hFFFF, 2'b11, 1'b0, 8'd0);
      step(1'b0, 8'd0, 16'h0000, 2'b00, 1'b1, 8'd250);
      checks++;
      if (rd_valid_w[2] !== 1'b1 || rd_data_w[2] !== 16'h0000) begin
         errors++; $display("FAIL oor_read: got %h valid %b, required 0000 valid 1", rd_data_w[2], rd_valid_w[2]);
      end
      checks++;
      if (rd_data_w[0] !== 16'hFFFF) begin
         errors++; $display("FAIL oor_inrange_256: got %h, required ffff", rd_data_w[0]);
      end
      step(1'b0, 8'd0, 16'h0000, 2'b00, 1'b1, 8'd50);
      idle(2);
      checks++;
      if (last_obs[2] !== 16'h0050) begin
         errors++; $display("FAIL oor_alias: got %h, required 0050", last_obs[2]);
      end
      for (int i = 0; i < NI; i++) begin
         checks++;
         if (obs_q[i].size() != exp_q[i].size()) begin
            errors++; $display("FAIL oor_count inst%0d: got %0d results, required %0d", i, obs_q[i].size(), exp_q[i].size());
         end
         while (exp_q[i].size() > 0 && obs_q[i].size() > 0) begin
            e = exp_q[i].pop_front(); o = obs_q[i].pop_front(); checks++;
            if (o.cyc != e.cyc || (!e.dc && o.d !== e.d)) begin
               errors++; $display("FAIL oor_data inst%0d: got %h @%0d, required %h @%0d", i, o.d, o.cyc, e.d, e.cyc);
            end
         end
         exp_q[i].delete(); obs_q[i].delete();
      end
   endtask

   initial begin
      rst_n = 1'b0;
      wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
      rd_en = 1'b0; rd_addr = '0;
      for (int i = 0; i < NI; i++) begin
         mdl_busy[i] = 1'b0;
         mdl_cnt[i]  = 0;
         last_obs[i] = 16'h0000;
         for (int a = 0; a < 256; a++) begin
            mdl_mem[i][a]   = 16'h0000;
            mdl_known[i][a] = 1'b0;
         end
      end
      test_reset();
      test_clear();
      test_byte_lanes();
      test_collision();
      test_back_to_back();
      test_busy_gating();
      test_out_of_range();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
